// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the flappy_bird draw_* layers.
package vga_pkg;

  localparam int HACT = 1024;
  localparam int VACT = 768;

  typedef logic [11:0] rgb_t;

  typedef enum logic [1:0] {
    HIDDEN,
    SLIDE_IN,
    SHOWN,
    SLIDE_OUT
  } panel_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bus shared by the draw_* layers.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblank;
  logic        vblank;

  modport in  (input  hcount, vcount, hsync, vsync, hblank, vblank);
  modport out (output hcount, vcount, hsync, vsync, hblank, vblank);

endinterface

// File: rtl/draw_start_panel_frame_ticker.sv
// One-cycle frame pulse, registered from the top-left pixel of the timing bus.
module frame_ticker (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        frame_tick
);

  always_ff @(posedge clk) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= (hcount == 11'd0) && (vcount == 11'd0);
  end

endmodule

// File: rtl/draw_start_panel.sv
// Start-screen overlay: bordered panel with a blinking prompt strip that
// slides vertically in and out of view under show/hide control.
module draw_start_panel
  import vga_pkg::*;
#(
  parameter int unsigned X0           = 400,
  parameter int unsigned Y0           = 300,
  parameter int unsigned W            = 200,
  parameter int unsigned H            = 100,
  parameter int unsigned BORDER       = 4,
  parameter int unsigned PX           = 20,
  parameter int unsigned PY           = 40,
  parameter int unsigned PW           = 160,
  parameter int unsigned PH           = 20,
  parameter rgb_t        FILL_RGB     = 12'hF00,
  parameter rgb_t        BORDER_RGB   = 12'hFFF,
  parameter rgb_t        PROMPT_RGB   = 12'hFF0,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned SLIDE_OFF    = 256,
  parameter int unsigned SLIDE_STEP   = 8
) (
  input  logic clk,
  input  logic rst,
  vga_if.in    vin,
  input  logic show,
  input  logic hide,
  output rgb_t rgb,
  output logic valid,
  output logic active,
  output logic done
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [11:0] X_L      = 12'(X0);
  localparam logic [11:0] X_R      = 12'(X0 + W);
  localparam logic [11:0] XB_L     = 12'(X0 + BORDER);
  localparam logic [11:0] XB_R     = 12'(X0 + W - BORDER);
  localparam logic [11:0] PX_L     = 12'(X0 + PX);
  localparam logic [11:0] PX_R     = 12'(X0 + PX + PW);
  localparam logic [11:0] Y0_L     = 12'(Y0);
  localparam logic [11:0] H_L      = 12'(H);
  localparam logic [11:0] BORDER_L = 12'(BORDER);
  localparam logic [11:0] PY_L     = 12'(PY);
  localparam logic [11:0] PH_L     = 12'(PH);
  localparam logic [11:0] OFF_MAX  = 12'(SLIDE_OFF);
  localparam logic [11:0] STEP     = 12'(SLIDE_STEP);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

  panel_state_t  state;
  logic [11:0]   y_off;
  logic [CW-1:0] blink_cnt;
  logic          blink_on;
  logic          frame_tick;

  logic [11:0] h, v, top, bottom, p_top, p_bot;
  logic [12:0] out_sum;
  logic        in_panel, in_border, in_prompt;
  logic        unused_sync;

  assign unused_sync = ^{vin.hsync, vin.vsync, vin.hblank, vin.vblank};

  frame_ticker u_ticker (
    .clk        (clk),
    .rst        (rst),
    .hcount     (vin.hcount),
    .vcount     (vin.vcount),
    .frame_tick (frame_tick)
  );

  assign out_sum = {1'b0, y_off} + {1'b0, STEP};
  assign active  = (state != HIDDEN);

  // Requests change state at once; y_off only moves on frame_tick so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HIDDEN;
      y_off <= OFF_MAX;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        HIDDEN: if (show && !hide) state <= SLIDE_IN;
        SLIDE_IN: begin
          if (hide) begin
            state <= SLIDE_OUT;
          end else if (frame_tick) begin
            if (y_off <= STEP) begin
              y_off <= 12'd0;
              state <= SHOWN;
              done  <= 1'b1;
            end else begin
              y_off <= y_off - STEP;
            end
          end
        end
        SHOWN: if (hide) state <= SLIDE_OUT;
        SLIDE_OUT: begin
          if (show && !hide) begin
            state <= SLIDE_IN;
          end else if (frame_tick) begin
            if (out_sum >= {1'b0, OFF_MAX}) begin
              y_off <= OFF_MAX;
              state <= HIDDEN;
              done  <= 1'b1;
            end else begin
              y_off <= out_sum[11:0];
            end
          end
        end
        default: state <= HIDDEN;
      endcase
    end
  end

  // Outside SHOWN the counter is parked, so entering SHOWN starts a fresh "on" phase.
  always_ff @(posedge clk) begin
    if (rst || state != SHOWN) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    h         = {1'b0, vin.hcount};
    v         = {1'b0, vin.vcount};
    top       = Y0_L + y_off;
    bottom    = top + H_L;
    p_top     = top + PY_L;
    p_bot     = p_top + PH_L;
    in_panel  = (h >= X_L) && (h < X_R) && (v >= top) && (v < bottom);
    in_border = in_panel && ((h < XB_L) || (h >= XB_R) ||
                             (v < top + BORDER_L) || (v >= bottom - BORDER_L));
    in_prompt = (h >= PX_L) && (h < PX_R) && (v >= p_top) && (v < p_bot);
  end

  always_ff @(posedge clk) begin
    if (rst || state == HIDDEN) begin
      rgb   <= '0;
      valid <= 1'b0;
    end else if (in_border) begin
      rgb   <= BORDER_RGB;
      valid <= 1'b1;
    end else if (in_prompt && blink_on) begin
      rgb   <= PROMPT_RGB;
      valid <= 1'b1;
    end else if (in_panel) begin
      rgb   <= FILL_RGB;
      valid <= 1'b1;
    end else begin
      rgb   <= '0;
      valid <= 1'b0;
    end
  end

endmodule
